// File: rtl/wdt_pkg.sv
// Watchdog shared definitions.
//   wdt_state_t : FSM encoding, also driven out on the watchdog `state` port
//   DEF_*       : default parameter values for the watchdog top
package wdt_pkg;

  // 2'd3 is never produced; the FSM treats it like IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    BITE = 2'd2
  } wdt_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RST_PULSE   = 16;

endpackage

// File: rtl/wdt_tick_sync.sv
// Brings the slow, asynchronous watchdog timebase into the clk domain and
// turns each of its rising edges into a single-cycle tick.
//   clk     in  : main clock
//   reset   in  : asynchronous, active-high
//   wdt_clk in  : asynchronous timebase
//   tick    out : one clk-cycle pulse per wdt_clk rising edge
module wdt_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic wdt_clk,
  output logic tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], wdt_clk};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronized timebase; both inputs are flops.
  assign tick = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/watchdog.sv
// Windowed watchdog timer with pre-timeout warning and fixed-length reset
// request.
//   clk, reset      : main clock, asynchronous active-high reset
//   wdt_clk         : asynchronous countdown timebase
//   enable          : level, arms the watchdog
//   kick            : single-cycle service pulse
//   cfg_timeout     : reload value in ticks (0 behaves as 1)
//   cfg_window      : kick legal only while count <= window
//   cfg_warn        : warning threshold
//   count, state    : current countdown value and FSM state (debug view)
//   warn_irq        : level warning while RUN and 0 < count <= warn
//   early_kick_err  : one-cycle pulse on a kick above the window
//   sys_rst_req     : high for RST_PULSE cycles per bite
module watchdog
  import wdt_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_PULSE   = DEF_RST_PULSE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wdt_clk,
  input  logic             enable,
  input  logic             kick,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_warn,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state,
  output logic             warn_irq,
  output logic             early_kick_err,
  output logic             sys_rst_req
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  wdt_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_timeout_sh;
  logic [CNT_W-1:0] r_window_sh;
  logic [CNT_W-1:0] r_warn_sh;
  logic [PW-1:0]    r_pulse;
  logic             r_warn;
  logic             r_err;
  logic             r_rst_req;

  wdt_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_warn_sh_nxt;
  logic [CNT_W-1:0] w_reload;
  logic [PW-1:0]    w_pulse_nxt;
  logic             w_load;
  logic             w_err_nxt;
  logic             w_warn_nxt;
  logic             w_tick;

  wdt_tick_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .clk     (clk),
    .reset   (reset),
    .wdt_clk (wdt_clk),
    .tick    (w_tick)
  );

  // Fresh reload value used whenever config is (re)captured.
  assign w_reload = (cfg_timeout == '0) ? CNT_W'(1) : cfg_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pulse_nxt = r_pulse;
    w_load      = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      RUN: begin
        // Disable outranks kick and tick.
        if (!enable) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end else if (kick) begin
          if (r_count <= r_window_sh) begin
            w_count_nxt = r_timeout_sh;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = BITE;
            w_pulse_nxt = '0;
          end
        end else if (w_tick) begin
          if (r_count > CNT_W'(1)) begin
            w_count_nxt = r_count - CNT_W'(1);
          end else begin
            w_count_nxt = '0;
            w_state_nxt = BITE;
            w_pulse_nxt = '0;
          end
        end
      end
      BITE: begin
        // count holds; only the pulse counter advances.
        if (r_pulse == PW'(RST_PULSE - 1)) begin
          w_pulse_nxt = '0;
          if (enable) begin
            w_state_nxt = RUN;
            w_count_nxt = w_reload;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end
        end else begin
          w_pulse_nxt = r_pulse + PW'(1);
        end
      end
      default: begin
        w_count_nxt = '0;
        w_pulse_nxt = '0;
        if (enable) begin
          w_state_nxt = RUN;
          w_count_nxt = w_reload;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase

    // Warning is computed from next-cycle values so it lines up with count.
    w_warn_sh_nxt = w_load ? cfg_warn : r_warn_sh;
    w_warn_nxt    = (w_state_nxt == RUN) && (w_count_nxt != '0) &&
                    (w_count_nxt <= w_warn_sh_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_timeout_sh <= '0;
      r_window_sh  <= '0;
      r_warn_sh    <= '0;
      r_pulse      <= '0;
      r_warn       <= 1'b0;
      r_err        <= 1'b0;
      r_rst_req    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_pulse   <= w_pulse_nxt;
      r_warn    <= w_warn_nxt;
      r_err     <= w_err_nxt;
      r_rst_req <= (w_state_nxt == BITE);
      r_warn_sh <= w_warn_sh_nxt;
      if (w_load) begin
        r_timeout_sh <= w_reload;
        r_window_sh  <= cfg_window;
      end
    end
  end

  assign count          = r_count;
  assign state          = r_state;
  assign warn_irq       = r_warn;
  assign early_kick_err = r_err;
  assign sys_rst_req    = r_rst_req;

endmodule

// File: tb/tb_watchdog.sv
module tb_watchdog;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int RST_PULSE   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             wdt_clk;
  logic             enable;
  logic             kick;
  logic [CNT_W-1:0] cfg_timeout;
  logic [CNT_W-1:0] cfg_window;
  logic [CNT_W-1:0] cfg_warn;
  logic [CNT_W-1:0] count;
  logic [1:0]       state;
  logic             warn_irq;
  logic             early_kick_err;
  logic             sys_rst_req;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: abstract watchdog behaviour, one update per operation.
  bit          m_run;
  bit          m_bite;
  int unsigned m_count;
  int unsigned m_to;
  int unsigned m_win;
  int unsigned m_warn;

  watchdog #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_PULSE   (RST_PULSE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wdt_clk        (wdt_clk),
    .enable         (enable),
    .kick           (kick),
    .cfg_timeout    (cfg_timeout),
    .cfg_window     (cfg_window),
    .cfg_warn       (cfg_warn),
    .count          (count),
    .state          (state),
    .warn_irq       (warn_irq),
    .early_kick_err (early_kick_err),
    .sys_rst_req    (sys_rst_req)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_err);
    logic [1:0] es;
    logic       ew;
    es = m_bite ? 2'd2 : (m_run ? 2'd1 : 2'd0);
    ew = m_run && (m_count != 0) && (m_count <= m_warn);
    chk({tag, ".state"}, 64'(state), 64'(es));
    chk({tag, ".count"}, 64'(count), 64'(m_count));
    chk({tag, ".warn"}, 64'(warn_irq), 64'(ew));
    chk({tag, ".err"}, 64'(early_kick_err), 64'(exp_err));
    chk({tag, ".rst_req"}, 64'(sys_rst_req), 64'(m_bite));
  endtask

  task automatic arm();
    m_to    = (cfg_timeout == 0) ? 1 : int'(cfg_timeout);
    m_win   = cfg_window;
    m_warn  = cfg_warn;
    m_count = m_to;
    m_run   = 1'b1;
  endtask

  // Called in the first BITE cycle; counts high cycles of sys_rst_req.
  task automatic measure_bite(input int drop_at);
    int n;
    n = 0;
    while (sys_rst_req === 1'b1 && n < 4 * RST_PULSE) begin
      if (n == drop_at) enable = 1'b0;
      n++;
      @(posedge clk); #1;
    end
    chk("pulse_len", 64'(n), 64'(RST_PULSE));
    m_bite = 1'b0;
    if (enable) arm();
    else begin
      m_run   = 1'b0;
      m_count = 0;
    end
    check_all("after_bite", 1'b0);
  endtask

  task automatic model_kick(output logic err);
    err = 1'b0;
    if (m_run) begin
      if (m_count <= m_win) m_count = m_to;
      else begin
        m_run  = 1'b0;
        m_bite = 1'b1;
        err    = 1'b1;
      end
    end
  endtask

  task automatic step_tick(input int drop_at);
    wdt_clk = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    if (m_run) begin
      if (m_count > 1) m_count--;
      else begin
        m_count = 0;
        m_run   = 1'b0;
        m_bite  = 1'b1;
      end
    end
    check_all("tick", 1'b0);
    if (m_bite) measure_bite(drop_at);
    wdt_clk = 1'b0;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
  endtask

  task automatic step_kick(input int drop_at);
    logic err;
    kick = 1'b1;
    @(posedge clk); #1;
    kick = 1'b0;
    model_kick(err);
    check_all("kick", err);
    if (m_bite) measure_bite(drop_at);
  endtask

  // Kick lands in the same cycle as the internal tick.
  task automatic step_collide();
    logic err;
    wdt_clk = 1'b1;
    repeat (SYNC_STAGES) @(posedge clk);
    #1;
    kick = 1'b1;
    @(posedge clk); #1;
    kick = 1'b0;
    model_kick(err);
    check_all("collide", err);
    if (m_bite) measure_bite(-1);
    wdt_clk = 1'b0;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
  endtask

  task automatic step_enable(input logic v);
    enable = v;
    @(posedge clk); #1;
    if (v && !m_run) arm();
    else if (!v && m_run) begin
      m_run   = 1'b0;
      m_count = 0;
    end
    check_all("enable", 1'b0);
  endtask

  task automatic step_cfg(input int t, input int w, input int wa);
    cfg_timeout = CNT_W'(t);
    cfg_window  = CNT_W'(w);
    cfg_warn    = CNT_W'(wa);
    @(posedge clk); #1;
    check_all("cfg", 1'b0);
  endtask

  initial begin
    // Reset
    reset       = 1'b1;
    wdt_clk     = 1'b0;
    enable      = 1'b0;
    kick        = 1'b0;
    cfg_timeout = '0;
    cfg_window  = '0;
    cfg_warn    = '0;
    m_run = 1'b0; m_bite = 1'b0; m_count = 0; m_to = 0; m_win = 0; m_warn = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Timeout: 4,3,2,1,0, bite, back to RUN at 4
    step_cfg(4, 4, 2);
    step_enable(1'b1);
    repeat (4) step_tick(-1);

    // Legal kick at count 3 with warn active
    step_enable(1'b0);
    step_cfg(8, 3, 4);
    step_enable(1'b1);
    repeat (5) step_tick(-1);
    step_kick(-1);

    // Early kick at count 6
    repeat (2) step_tick(-1);
    step_kick(-1);

    // Kick/tick collision at count 2, window 8
    step_enable(1'b0);
    step_cfg(8, 8, 4);
    step_enable(1'b1);
    repeat (6) step_tick(-1);
    step_collide();

    // Config change in RUN is ignored
    step_cfg(3, 0, 0);
    step_tick(-1);

    // Disable during BITE: full pulse, then IDLE
    step_enable(1'b0);
    step_cfg(2, 2, 0);
    step_enable(1'b1);
    step_tick(-1);
    step_tick(3);

    // Disable in RUN
    step_enable(1'b1);
    step_tick(-1);
    step_enable(1'b0);

    // Timeout 0 behaves as 1: first tick bites
    step_cfg(0, 0, 0);
    step_enable(1'b1);
    step_tick(-1);
    step_enable(1'b0);

    // Asynchronous reset mid-RUN at count 5
    step_cfg(7, 7, 3);
    step_enable(1'b1);
    repeat (2) step_tick(-1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_run = 1'b0; m_bite = 1'b0; m_count = 0;
    check_all("async_reset", 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset", 1'b0);

    // Randomized operations
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) step_tick(-1);
      else if (op <= 6) step_kick(-1);
      else if (op == 7) step_cfg($urandom_range(0, 10), $urandom_range(0, 12), $urandom_range(0, 10));
      else if (op == 8) begin
        if (!enable) begin
          cfg_timeout = CNT_W'($urandom_range(0, 10));
          cfg_window  = CNT_W'($urandom_range(0, 12));
          cfg_warn    = CNT_W'($urandom_range(0, 10));
          step_enable(1'b1);
        end else step_enable(1'b0);
      end else begin
        @(posedge clk); #1;
        check_all("idle_cycle", 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
